oc8051_etr_bank: RTL and testbench
==================================

OC8051_ETR_BANK -- requirements
Module: oc8051_etr_bank

Interface
REQ-001 Parameter NUM_TGT, default 4, number of ecall target entries (1..8).
REQ-002 Parameter SFR_LO, default `OC8051_SFR_ETR_LO, SFR address of the low-byte stage.
REQ-003 Parameter SFR_HI, default `OC8051_SFR_ETR_HI, SFR address of the high-byte commit.
REQ-004 Parameter SFR_SEL, default `OC8051_SFR_ETR_SEL, SFR address of the index/lock control.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 priv_lvl  in  1  1 = privileged; SFR writes are ignored when 0.
REQ-008 wr  in  1  SFR write strobe.
REQ-009 wr_bit  in  1  bit-addressed write; byte writes require wr_bit=0.
REQ-010 wr_addr  in  8  SFR write address.
REQ-011 data_in  in  8  SFR write data.
REQ-012 rd_addr  in  8  SFR read address.
REQ-013 data_out  out  8  SFR read data, combinational.
REQ-014 ecall_req  in  1  ecall lookup request, held until ecall_ack.
REQ-015 ecall_idx  in  3  requested entry index.
REQ-016 ecall_ack  out  1  one-cycle response pulse.
REQ-017 ecall_tgt  out  16  target address, valid with ecall_ack.
REQ-018 ecall_err  out  1  index out of range or entry unprogrammed, valid with ecall_ack.

Function
REQ-019 The block holds NUM_TGT entries, each with a 16-bit target, a prog bit and a lock bit.
REQ-020 A privileged byte write to SFR_SEL sets sel = data_in[2:0]; data_in[7]=1 also sets lock[sel] for the new sel.
REQ-021 A privileged byte write to SFR_LO loads stage_lo = data_in and sets stage_vld.
REQ-022 A privileged byte write to SFR_HI with stage_vld=1, sel<NUM_TGT and lock[sel]=0 commits {data_in, stage_lo} to entry[sel], sets prog[sel], and clears stage_vld, all in one edge.
REQ-023 An SFR_HI write with stage_vld=0 is ignored and leaves no partial update; stage_vld is cleared in that case and on any locked or out-of-range SFR_HI write.
REQ-024 A write to SFR_SEL clears stage_vld, so a staged low byte never crosses entries.
REQ-025 Once set, a lock bit stays set until reset.
REQ-026 data_out = entry[sel][7:0] for SFR_LO, entry[sel][15:8] for SFR_HI, and {lock[sel], prog[sel], stage_vld, 2'b0, sel} for SFR_SEL; all other addresses read 8'h00, as does an out-of-range sel.
REQ-027 The ecall FSM has states IDLE, LOOK and RESP.
REQ-028 IDLE -> LOOK when ecall_req=1; ecall_idx is captured on that edge.
REQ-029 LOOK -> RESP unconditionally; entry data is registered on this edge.
REQ-030 In RESP, ecall_ack=1 for exactly one cycle, then the FSM returns to IDLE. The total latency from the req-sampling edge to ack is 2 cycles.
REQ-031 ecall_err=1 when idx>=NUM_TGT or prog[idx]=0; in that case ecall_tgt=16'h0000.
REQ-032 A commit on the same edge as the LOOK sample returns the pre-commit entry value.
REQ-033 A new request is accepted only in IDLE. If ecall_req is still high in the cycle after ack, a fresh lookup starts.
REQ-034 ecall_tgt and ecall_err are held stable outside RESP at their last values.

Reset
REQ-035 On rst=0, all of the following are cleared: entries to 16'h0000, prog, lock, stage_lo, stage_vld, sel and ecall_tgt; ecall_ack=0, ecall_err=0, FSM=IDLE.
REQ-036 Reset mid-lookup abandons the lookup with no ack after release.
REQ-037 Reset deassertion is synchronised externally; the block needs no internal synchroniser.

Structure
REQ-038 SFR address defines and FSM state encodings live in the shared oc8051_defines.v.
REQ-039 The per-entry target/prog/lock storage is one sub-module, oc8051_etr_entry, instantiated NUM_TGT times by generate.

Verification
REQ-040 Priv write SEL=0x01, LO=0x34, HI=0x12, then request idx 1 -> ack 2 cycles later with tgt=16'h1234, err=0.
REQ-041 priv_lvl=0 write sequence to entry 0 -> entry unchanged, SEL reads prog=0; request idx 0 -> err=1, tgt=0.
REQ-042 HI=0xAB without preceding LO -> entry unchanged; LO=0xCD, SEL=0x02, HI=0xEF -> entry 2 unchanged, stage_vld=0.
REQ-043 SEL=0x80 after programming entry 0 with 16'h5555, then LO/HI writes of 16'hAAAA -> entry stays 16'h5555, lock reads 1.
REQ-044 HI commit of 16'h2222 on the LOOK edge for the same idx, previously 16'h1111 -> ack returns 16'h1111; next lookup returns 16'h2222.
REQ-045 NUM_TGT=4 with request idx 5 -> err=1. rst=0 asserted during LOOK -> no ack, all outputs 0.

Source files
------------

// File: rtl/oc8051_etr_bank_pkg.sv
// Shared constants for the ecall target register bank: SFR addresses,
// lookup FSM encodings and a small range helper.
package oc8051_etr_bank_pkg;

  localparam logic [7:0] OC8051_SFR_ETR_LO  = 8'hE9;
  localparam logic [7:0] OC8051_SFR_ETR_HI  = 8'hEA;
  localparam logic [7:0] OC8051_SFR_ETR_SEL = 8'hEB;

  localparam logic [1:0] ETR_ST_IDLE = 2'd0;
  localparam logic [1:0] ETR_ST_LOOK = 2'd1;
  localparam logic [1:0] ETR_ST_RESP = 2'd2;

  localparam int unsigned ETR_MAX_TGT = 8;

  function automatic logic etr_in_range(input logic [2:0] idx, input int unsigned num);
    return ({29'd0, idx} < num);
  endfunction

endpackage

// File: rtl/oc8051_etr_bank_entry.sv
// One ecall target slot: 16-bit target, programmed flag and sticky lock.
module oc8051_etr_entry (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit,
  input  logic        lock_set,
  input  logic [15:0] tgt_in,
  output logic [15:0] tgt,
  output logic        prog,
  output logic        lock
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tgt  <= '0;
      prog <= 1'b0;
      lock <= 1'b0;
    end else begin
      if (commit) begin
        tgt  <= tgt_in;
        prog <= 1'b1;
      end
      if (lock_set)
        lock <= 1'b1;
    end
  end

endmodule

// File: rtl/oc8051_etr_bank.sv
// Ecall target register bank: SFR-programmed target table with a
// three-state lookup engine answering ecall index requests.
module oc8051_etr_bank
  import oc8051_etr_bank_pkg::*;
#(
  parameter int unsigned NUM_TGT = 4,
  parameter logic [7:0]  SFR_LO  = OC8051_SFR_ETR_LO,
  parameter logic [7:0]  SFR_HI  = OC8051_SFR_ETR_HI,
  parameter logic [7:0]  SFR_SEL = OC8051_SFR_ETR_SEL
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        priv_lvl,
  input  logic        wr,
  input  logic        wr_bit,
  input  logic [7:0]  wr_addr,
  input  logic [7:0]  data_in,
  input  logic [7:0]  rd_addr,
  output logic [7:0]  data_out,
  input  logic        ecall_req,
  input  logic [2:0]  ecall_idx,
  output logic        ecall_ack,
  output logic [15:0] ecall_tgt,
  output logic        ecall_err
);

  logic [2:0]  sel;
  logic [7:0]  stage_lo;
  logic        stage_vld;
  logic [1:0]  state;
  logic [2:0]  idx_q;

  logic [15:0] tgt_vec [NUM_TGT];
  logic [NUM_TGT-1:0] prog_vec;
  logic [NUM_TGT-1:0] lock_vec;

  // Zero-padded to the full 3-bit index space so out-of-range reads yield 0.
  logic [15:0] tgt_all [ETR_MAX_TGT];
  logic [ETR_MAX_TGT-1:0] prog_all;
  logic [ETR_MAX_TGT-1:0] lock_all;

  logic byte_wr, wr_sel, wr_lo, wr_hi, hi_ok;
  logic [15:0] look_tgt;
  logic        look_err;

  assign byte_wr = wr & ~wr_bit & priv_lvl;
  assign wr_sel  = byte_wr & (wr_addr == SFR_SEL);
  assign wr_lo   = byte_wr & (wr_addr == SFR_LO);
  assign wr_hi   = byte_wr & (wr_addr == SFR_HI);
  assign hi_ok   = wr_hi & stage_vld & etr_in_range(sel, NUM_TGT) & ~lock_all[sel];

  always_comb begin
    for (int unsigned i = 0; i < ETR_MAX_TGT; i++)
      tgt_all[i] = '0;
    for (int unsigned i = 0; i < NUM_TGT; i++)
      tgt_all[i] = tgt_vec[i];
    prog_all = ETR_MAX_TGT'(prog_vec);
    lock_all = ETR_MAX_TGT'(lock_vec);
  end

  for (genvar g = 0; g < NUM_TGT; g++) begin : g_entry
    oc8051_etr_entry u_entry (
      .clk      (clk),
      .rst      (rst),
      .commit   (hi_ok & (sel == 3'(g))),
      .lock_set (wr_sel & data_in[7] & (data_in[2:0] == 3'(g))),
      .tgt_in   ({data_in, stage_lo}),
      .tgt      (tgt_vec[g]),
      .prog     (prog_vec[g]),
      .lock     (lock_vec[g])
    );
  end

  // Any SEL or HI write drops the staged byte; only LO arms it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel       <= '0;
      stage_lo  <= '0;
      stage_vld <= 1'b0;
    end else if (wr_sel) begin
      sel       <= data_in[2:0];
      stage_vld <= 1'b0;
    end else if (wr_lo) begin
      stage_lo  <= data_in;
      stage_vld <= 1'b1;
    end else if (wr_hi) begin
      stage_vld <= 1'b0;
    end
  end

  always_comb begin
    data_out = '0;
    if (rd_addr == SFR_LO)
      data_out = tgt_all[sel][7:0];
    else if (rd_addr == SFR_HI)
      data_out = tgt_all[sel][15:8];
    else if (rd_addr == SFR_SEL)
      data_out = {lock_all[sel], prog_all[sel], stage_vld, 2'b00, sel};
  end

  always_comb begin
    look_err = ~etr_in_range(idx_q, NUM_TGT) | ~prog_all[idx_q];
    look_tgt = look_err ? 16'h0000 : tgt_all[idx_q];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ETR_ST_IDLE;
      idx_q     <= '0;
      ecall_tgt <= '0;
      ecall_err <= 1'b0;
    end else begin
      case (state)
        ETR_ST_IDLE: begin
          if (ecall_req) begin
            state <= ETR_ST_LOOK;
            idx_q <= ecall_idx;
          end
        end
        ETR_ST_LOOK: begin
          state     <= ETR_ST_RESP;
          ecall_tgt <= look_tgt;
          ecall_err <= look_err;
        end
        ETR_ST_RESP: state <= ETR_ST_IDLE;
        default:     state <= ETR_ST_IDLE;
      endcase
    end
  end

  assign ecall_ack = (state == ETR_ST_RESP);

endmodule

// File: tb/tb_oc8051_etr_bank.sv
// Directed bench for oc8051_etr_bank: SFR vector table plus hand-written
// lookup sequences for latency, commit collision and reset abort.
module tb_oc8051_etr_bank;
  import oc8051_etr_bank_pkg::*;

  localparam logic [7:0] LO  = OC8051_SFR_ETR_LO;
  localparam logic [7:0] HI  = OC8051_SFR_ETR_HI;
  localparam logic [7:0] SEL = OC8051_SFR_ETR_SEL;

  logic        clk = 1'b0;
  logic        rst, priv_lvl, wr, wr_bit;
  logic [7:0]  wr_addr, data_in, rd_addr, data_out;
  logic        ecall_req, ecall_ack, ecall_err;
  logic [2:0]  ecall_idx;
  logic [15:0] ecall_tgt;

  int passed = 0;
  int total  = 0;

  typedef struct {
    bit         rd;
    bit         priv;
    bit         wbit;
    logic [7:0] addr;
    logic [7:0] val;
  } vec_t;

  vec_t vecs[$];

  oc8051_etr_bank #(.NUM_TGT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .priv_lvl  (priv_lvl),
    .wr        (wr),
    .wr_bit    (wr_bit),
    .wr_addr   (wr_addr),
    .data_in   (data_in),
    .rd_addr   (rd_addr),
    .data_out  (data_out),
    .ecall_req (ecall_req),
    .ecall_idx (ecall_idx),
    .ecall_ack (ecall_ack),
    .ecall_tgt (ecall_tgt),
    .ecall_err (ecall_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t w(input bit priv, input bit wbit, input logic [7:0] a, input logic [7:0] d);
    vec_t v;
    v.rd = 1'b0; v.priv = priv; v.wbit = wbit; v.addr = a; v.val = d;
    return v;
  endfunction

  function automatic vec_t r(input logic [7:0] a, input logic [7:0] e);
    vec_t v;
    v.rd = 1'b1; v.priv = 1'b1; v.wbit = 1'b0; v.addr = a; v.val = e;
    return v;
  endfunction

  task automatic run_vectors(input int first, input int last);
    for (int i = first; i < last; i++) begin
      @(negedge clk);
      if (vecs[i].rd) begin
        wr = 1'b0;
        rd_addr = vecs[i].addr;
        #1;
        check($sformatf("vec%0d_rd_%h", i, vecs[i].addr), {8'h00, data_out}, {8'h00, vecs[i].val});
      end else begin
        wr = 1'b1; priv_lvl = vecs[i].priv; wr_bit = vecs[i].wbit;
        wr_addr = vecs[i].addr; data_in = vecs[i].val;
      end
    end
    @(negedge clk);
    wr = 1'b0; priv_lvl = 1'b1; wr_bit = 1'b0;
  endtask

  task automatic lookup(input logic [2:0] idx, input logic [15:0] exp_tgt, input logic exp_err);
    @(negedge clk);
    wr = 1'b0; ecall_req = 1'b1; ecall_idx = idx;
    @(posedge clk); #1;
    check($sformatf("look%0d_ack_early", idx), {15'd0, ecall_ack}, 16'd0);
    @(negedge clk);
    ecall_req = 1'b0;
    @(posedge clk); #1;
    check($sformatf("look%0d_ack", idx), {15'd0, ecall_ack}, 16'd1);
    check($sformatf("look%0d_tgt", idx), ecall_tgt, exp_tgt);
    check($sformatf("look%0d_err", idx), {15'd0, ecall_err}, {15'd0, exp_err});
    @(posedge clk); #1;
    check($sformatf("look%0d_ack_drop", idx), {15'd0, ecall_ack}, 16'd0);
    check($sformatf("look%0d_tgt_hold", idx), ecall_tgt, exp_tgt);
  endtask

  int m0, m1, m2, m3, m4, m5;
  logic exp_pat [6];

  initial begin
    rst = 1'b0; priv_lvl = 1'b1; wr = 1'b0; wr_bit = 1'b0;
    wr_addr = '0; data_in = '0; rd_addr = SEL; ecall_req = 1'b0; ecall_idx = '0;

    vecs.push_back(r(SEL, 8'h00)); vecs.push_back(r(LO, 8'h00));
    vecs.push_back(w(1, 0, SEL, 8'h01)); vecs.push_back(w(1, 0, LO, 8'h34));
    vecs.push_back(r(SEL, 8'h21)); vecs.push_back(w(1, 0, HI, 8'h12));
    vecs.push_back(r(LO, 8'h34)); vecs.push_back(r(HI, 8'h12));
    vecs.push_back(r(SEL, 8'h41));
    m0 = vecs.size();
    vecs.push_back(w(1, 0, SEL, 8'h00)); vecs.push_back(w(0, 0, LO, 8'h77));
    vecs.push_back(w(0, 0, HI, 8'h66)); vecs.push_back(r(SEL, 8'h00));
    vecs.push_back(r(LO, 8'h00)); vecs.push_back(w(0, 0, SEL, 8'h03));
    vecs.push_back(r(SEL, 8'h00)); vecs.push_back(w(1, 1, LO, 8'h99));
    vecs.push_back(r(SEL, 8'h00));
    m1 = vecs.size();
    vecs.push_back(w(1, 0, SEL, 8'h02)); vecs.push_back(w(1, 0, HI, 8'hAB));
    vecs.push_back(r(HI, 8'h00)); vecs.push_back(r(SEL, 8'h02));
    vecs.push_back(w(1, 0, LO, 8'hCD)); vecs.push_back(r(SEL, 8'h22));
    vecs.push_back(w(1, 0, SEL, 8'h02)); vecs.push_back(r(SEL, 8'h02));
    vecs.push_back(w(1, 0, HI, 8'hEF)); vecs.push_back(r(LO, 8'h00));
    vecs.push_back(r(HI, 8'h00)); vecs.push_back(r(SEL, 8'h02));
    m2 = vecs.size();
    vecs.push_back(w(1, 0, SEL, 8'h00)); vecs.push_back(w(1, 0, LO, 8'h55));
    vecs.push_back(w(1, 0, HI, 8'h55)); vecs.push_back(r(SEL, 8'h40));
    vecs.push_back(w(1, 0, SEL, 8'h80)); vecs.push_back(r(SEL, 8'hC0));
    vecs.push_back(w(1, 0, LO, 8'hAA)); vecs.push_back(r(SEL, 8'hE0));
    vecs.push_back(w(1, 0, HI, 8'hAA)); vecs.push_back(r(LO, 8'h55));
    vecs.push_back(r(HI, 8'h55)); vecs.push_back(r(SEL, 8'hC0));
    vecs.push_back(w(1, 0, SEL, 8'h00)); vecs.push_back(r(SEL, 8'hC0));
    m3 = vecs.size();
    vecs.push_back(w(1, 0, SEL, 8'h03)); vecs.push_back(w(1, 0, LO, 8'h11));
    vecs.push_back(w(1, 0, HI, 8'h11)); vecs.push_back(r(SEL, 8'h43));
    vecs.push_back(w(1, 0, LO, 8'h22)); vecs.push_back(r(SEL, 8'h63));
    m4 = vecs.size();
    vecs.push_back(w(1, 0, SEL, 8'h05)); vecs.push_back(w(1, 0, LO, 8'h12));
    vecs.push_back(w(1, 0, HI, 8'h34)); vecs.push_back(r(LO, 8'h00));
    vecs.push_back(r(HI, 8'h00));
    m5 = vecs.size();

    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", {15'd0, ecall_ack}, 16'd0);
    check("rst_tgt", ecall_tgt, 16'h0000);
    check("rst_err", {15'd0, ecall_err}, 16'd0);
    @(negedge clk);
    rst = 1'b1;

    run_vectors(0, m0);
    lookup(3'd1, 16'h1234, 1'b0);

    // Request held high: ack every third cycle after the first sample.
    exp_pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    @(negedge clk);
    ecall_req = 1'b1; ecall_idx = 3'd1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check($sformatf("held_ack_c%0d", i), {15'd0, ecall_ack}, {15'd0, exp_pat[i]});
    end
    @(negedge clk);
    ecall_req = 1'b0;
    @(posedge clk); @(posedge clk);

    run_vectors(m0, m1);
    lookup(3'd0, 16'h0000, 1'b1);
    run_vectors(m1, m2);
    lookup(3'd2, 16'h0000, 1'b1);
    run_vectors(m2, m3);
    lookup(3'd0, 16'h5555, 1'b0);
    run_vectors(m3, m4);

    // HI commit lands on the same edge the lookup reads the entry.
    @(negedge clk);
    ecall_req = 1'b1; ecall_idx = 3'd3;
    @(posedge clk);
    @(negedge clk);
    ecall_req = 1'b0;
    wr = 1'b1; priv_lvl = 1'b1; wr_bit = 1'b0; wr_addr = HI; data_in = 8'h22;
    @(posedge clk); #1;
    check("coll_ack", {15'd0, ecall_ack}, 16'd1);
    check("coll_tgt", ecall_tgt, 16'h1111);
    check("coll_err", {15'd0, ecall_err}, 16'd0);
    @(negedge clk);
    wr = 1'b0; rd_addr = HI;
    #1;
    check("coll_hi_rd", {8'h00, data_out}, 16'h0022);
    lookup(3'd3, 16'h2222, 1'b0);

    run_vectors(m4, m5);
    lookup(3'd5, 16'h0000, 1'b1);
    lookup(3'd4, 16'h0000, 1'b1);
    lookup(3'd3, 16'h2222, 1'b0);

    // Reset asserted while the FSM sits in LOOK.
    @(negedge clk);
    ecall_req = 1'b1; ecall_idx = 3'd3;
    @(posedge clk); #1;
    ecall_req = 1'b0;
    rst = 1'b0;
    #1;
    check("rstlook_ack", {15'd0, ecall_ack}, 16'd0);
    check("rstlook_tgt", ecall_tgt, 16'h0000);
    check("rstlook_err", {15'd0, ecall_err}, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("rstlook_noack_c%0d", i), {15'd0, ecall_ack}, 16'd0);
    end
    rd_addr = SEL;
    #1;
    check("rstlook_sel_rd", {8'h00, data_out}, 16'h0000);
    rd_addr = LO;
    #1;
    check("rstlook_lo_rd", {8'h00, data_out}, 16'h0000);
    lookup(3'd3, 16'h0000, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
